// File: rtl/dpram_req_sched_if.sv
// Request/response channel between a requester and the dual-port RAM scheduler.
// One instance per RAM port (A, B).
interface dpram_req_sched_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/dpram_req_sched.sv
// Two-channel request scheduler for a true dual-port RAM: serialises
// same-address collisions, range-checks addresses, fixed-latency responses.
module dpram_req_sched #(
    parameter int DEPTH = 20,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    dpram_req_sched_if.slave        a_if,
    dpram_req_sched_if.slave        b_if,
    output logic                    ram_we_a,
    output logic                    ram_we_b,
    output logic [AW-1:0]           ram_add_a,
    output logic [AW-1:0]           ram_add_b,
    output logic [DW-1:0]           ram_data_a,
    output logic [DW-1:0]           ram_data_b,
    input  logic [DW-1:0]           ram_read_a,
    input  logic [DW-1:0]           ram_read_b,
    output logic [15:0]             conflict_cnt
);
    localparam logic [1:0] S_INIT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef struct packed {
        logic v;
        logic we;
        logic err;
    } tag_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    logic [1:0]  state_q, state_d;
    tag_t        a1_q, a1_d, b1_q, b1_d, a2_q, b2_q;
    req_t        ra_q, ra_d, rb_q, rb_d, hold_q, hold_d;
    logic [15:0] cnt_q, cnt_d;
    logic        run, a_acc, b_acc, a_oor, b_oor, collide;
    req_t        a_req, b_req;

    assign run   = (state_q == S_RUN);
    assign a_acc = run && a_if.req_valid;
    assign b_acc = run && b_if.req_valid;
    assign a_oor = (a_if.req_addr > LAST);
    assign b_oor = (b_if.req_addr > LAST);
    assign collide = a_acc && b_acc && !a_oor
                  && (a_if.req_addr == b_if.req_addr);

    // Read requests drive zero on the RAM data pins.
    assign a_req = '{we: a_if.req_we, addr: a_if.req_addr,
                     data: a_if.req_we ? a_if.req_wdata : {DW{1'b0}}};
    assign b_req = '{we: b_if.req_we, addr: b_if.req_addr,
                     data: b_if.req_we ? b_if.req_wdata : {DW{1'b0}}};

    always_comb begin
        state_d = state_q;
        a1_d    = '0;
        b1_d    = '0;
        ra_d    = '0;
        rb_d    = '0;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_INIT:  state_d = S_RUN;
            S_RUN:   if (collide) state_d = S_HOLD;
            S_HOLD:  state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
        if (a_acc) begin
            a1_d = '{v: 1'b1, we: a_if.req_we, err: a_oor};
            if (!a_oor) ra_d = a_req;
        end
        if (state_q == S_HOLD) begin
            b1_d = '{v: 1'b1, we: hold_q.we, err: 1'b0};
            rb_d = hold_q;
        end else if (collide) begin
            hold_d = b_req;
            if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        end else if (b_acc) begin
            b1_d = '{v: 1'b1, we: b_if.req_we, err: b_oor};
            if (!b_oor) rb_d = b_req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            a1_q    <= '0;
            b1_q    <= '0;
            a2_q    <= '0;
            b2_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            a2_q    <= a1_q;
            b2_q    <= b1_q;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ram_we_a   = ra_q.we;
    assign ram_add_a  = ra_q.addr;
    assign ram_data_a = ra_q.data;
    assign ram_we_b   = rb_q.we;
    assign ram_add_b  = rb_q.addr;
    assign ram_data_b = rb_q.data;
    assign conflict_cnt = cnt_q;

    assign a_if.req_ready = run;
    assign b_if.req_ready = run;

    // RAM read register is live in the response cycle, so data passes through.
    assign a_if.rsp_valid = a2_q.v;
    assign a_if.rsp_err   = a2_q.err;
    assign a_if.rsp_data  = (a2_q.v && !a2_q.we && !a2_q.err)
                          ? ram_read_a : {DW{1'b0}};
    assign b_if.rsp_valid = b2_q.v;
    assign b_if.rsp_err   = b2_q.err;
    assign b_if.rsp_data  = (b2_q.v && !b2_q.we && !b2_q.err)
                          ? ram_read_b : {DW{1'b0}};
endmodule

// File: tb/tb_dpram_req_sched.sv
// Scoreboard bench for dpram_req_sched with an external 20x8 dual-port RAM
// model and a transaction-level reference of the scheduler.
module tb_dpram_req_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dpram_req_sched_if #(.AW(8), .DW(8)) a_if ();
    dpram_req_sched_if #(.AW(8), .DW(8)) b_if ();

    logic        ram_we_a, ram_we_b;
    logic [7:0]  ram_add_a, ram_add_b, ram_data_a, ram_data_b;
    logic [7:0]  ram_read_a, ram_read_b;
    logic [15:0] conflict_cnt;

    dpram_req_sched #(.DEPTH(20), .AW(8), .DW(8)) dut (
        .clk(clk), .rst(rst), .a_if(a_if), .b_if(b_if),
        .ram_we_a(ram_we_a), .ram_we_b(ram_we_b),
        .ram_add_a(ram_add_a), .ram_add_b(ram_add_b),
        .ram_data_a(ram_data_a), .ram_data_b(ram_data_b),
        .ram_read_a(ram_read_a), .ram_read_b(ram_read_b),
        .conflict_cnt(conflict_cnt)
    );

    // External RAM: synchronous clear on rst, registered read.
    logic [7:0] mem [20];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 20; i++) mem[i] <= 8'h00;
            ram_read_a <= 8'h00;
            ram_read_b <= 8'h00;
        end else begin
            if (ram_we_a && ram_add_a < 20) mem[ram_add_a] <= ram_data_a;
            if (ram_we_b && ram_add_b < 20) mem[ram_add_b] <= ram_data_b;
            ram_read_a <= (ram_add_a < 20) ? mem[ram_add_a] : 8'h00;
            ram_read_b <= (ram_add_b < 20) ? mem[ram_add_b] : 8'h00;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        logic       err;
        logic [7:0] data;
    } exp_t;

    exp_t       q [2][$];
    logic [7:0] mdl [20];
    int         cnt_exp = 0;
    logic       rdy_exp = 1'b0;
    bit         armed = 1'b0;
    int         vec = 0;
    int         errs = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t model_op(input logic we, input logic [7:0] addr,
                                      input logic [7:0] wd, input int due);
        exp_t e;
        e.due = due;
        e.err = 1'b0;
        e.data = 8'h00;
        if (addr >= 20) e.err = 1'b1;
        else if (we) mdl[addr] = wd;
        else e.data = mdl[addr];
        return e;
    endfunction

    // Reference model: sees what is accepted at the coming edge.
    always @(negedge clk) begin
        bit aa, ba, col;
        if (armed) begin
            chk("a_req_ready", a_if.req_ready, rdy_exp);
            chk("b_req_ready", b_if.req_ready, rdy_exp);
            chk("conflict_cnt", conflict_cnt, cnt_exp);
        end
        aa = a_if.req_valid && a_if.req_ready && !rst;
        ba = b_if.req_valid && b_if.req_ready && !rst;
        col = aa && ba && a_if.req_addr < 20
           && a_if.req_addr == b_if.req_addr;
        if (rst) begin
            for (int p = 0; p < 2; p++)
                while (q[p].size() > 0 && q[p][$].due > cyc) void'(q[p].pop_back());
            for (int i = 0; i < 20; i++) mdl[i] = 8'h00;
            cnt_exp = 0;
            rdy_exp = 1'b0;
            armed = 1'b1;
        end else begin
            if (aa) q[0].push_back(model_op(a_if.req_we, a_if.req_addr,
                                            a_if.req_wdata, cyc + 2));
            if (ba) q[1].push_back(model_op(b_if.req_we, b_if.req_addr,
                                            b_if.req_wdata, cyc + (col ? 3 : 2)));
            if (col && cnt_exp != 65535) cnt_exp++;
            rdy_exp = !col;
        end
    end

    task automatic check_port(input int p, input string nm, input logic v,
                              input logic [7:0] d, input logic er);
        exp_t e;
        while (q[p].size() > 0 && q[p][0].due < cyc) begin
            vec++;
            errs++;
            $display("FAIL %s_rsp_missing: got none expected rsp due %0d at cycle %0d",
                     nm, q[p][0].due, cyc);
            void'(q[p].pop_front());
        end
        if (v) begin
            if (q[p].size() == 0 || q[p][0].due != cyc) begin
                vec++;
                errs++;
                $display("FAIL %s_rsp_unexpected: got valid expected none at cycle %0d",
                         nm, cyc);
            end else begin
                e = q[p].pop_front();
                chk({nm, "_rsp_data"}, d, e.data);
                chk({nm, "_rsp_err"}, er, e.err);
            end
        end
    endtask

    // Monitor: compares DUT responses and RAM-side safety each cycle.
    always @(negedge clk) begin
        if (armed) begin
            check_port(0, "a", a_if.rsp_valid, a_if.rsp_data, a_if.rsp_err);
            check_port(1, "b", b_if.rsp_valid, b_if.rsp_data, b_if.rsp_err);
            if (ram_we_a) chk("ram_add_a_range", ram_add_a < 20, 1);
            if (ram_we_b) chk("ram_add_b_range", ram_add_b < 20, 1);
            if (ram_we_a && ram_we_b)
                chk("ram_same_addr", ram_add_a != ram_add_b, 1);
        end
    end

    task automatic drv(input logic av, input logic aw, input logic [7:0] aa,
                       input logic [7:0] ad, input logic bv, input logic bw,
                       input logic [7:0] ba, input logic [7:0] bd);
        a_if.req_valid = av;
        a_if.req_we    = aw;
        a_if.req_addr  = aa;
        a_if.req_wdata = ad;
        b_if.req_valid = bv;
        b_if.req_we    = bw;
        b_if.req_addr  = ba;
        b_if.req_wdata = bd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        a_if.req_valid = 1'b0;
        b_if.req_valid = 1'b0;
        a_if.req_we = 1'b0;
        b_if.req_we = 1'b0;
        a_if.req_addr = 8'h00;
        b_if.req_addr = 8'h00;
        a_if.req_wdata = 8'h00;
        b_if.req_wdata = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(3);
        drv(1, 1, 5, 8'hA5, 0, 0, 0, 0);
        idle(1);
        drv(1, 0, 5, 0, 0, 0, 0, 0);
        idle(4);
        drv(1, 1, 3, 8'h11, 1, 1, 3, 8'h22);
        idle(3);
        drv(1, 0, 3, 0, 1, 0, 3, 0);
        idle(4);
        drv(1, 1, 7, 8'h01, 1, 1, 9, 8'h02);
        idle(2);
        drv(1, 0, 7, 0, 1, 0, 9, 0);
        idle(3);
        drv(1, 1, 20, 8'hFF, 0, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 10; i++)
            drv(1, 0, 8'(i), 0, 1, 0, 8'(i + 10), 0);
        idle(4);
        drv(1, 1, 4, 8'h33, 1, 1, 4, 8'h44);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(4);
        for (int k = 0; k < 3000; k++) begin
            int lim;
            lim = ((k / 200) % 2 == 1) ? 3 : 23;
            rst = ($urandom_range(0, 299) == 0);
            drv($urandom_range(0, 3) != 0, 1'($urandom),
                8'($urandom_range(0, lim)), 8'($urandom),
                $urandom_range(0, 3) != 0, 1'($urandom),
                8'($urandom_range(0, lim)), 8'($urandom));
        end
        rst = 1'b0;
        idle(8);
        chk("a_queue_drained", q[0].size(), 0);
        chk("b_queue_drained", q[1].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
